// File: rtl/bitty_core_param.sv
// bitty_core_param: multi-cycle 8-register ALU core (IDLE→LOAD→EXEC→WB→DONE)
// Ports:
//    clk         - rising-edge clock
//    reset       - asynchronous active-high reset
//    run         - instruction-valid strobe, only looked at in IDLE
//    instruction - 16-bit word {Rx, Ry/imm8, op, fmt}, latched on accept
//    done        - registered one-cycle completion pulse
//    busy        - high whenever the core is not in IDLE
//    carry_flag  - carry / no-borrow of the last add or sub
//    eq_flag     - A==B of the last cmp
//    lt_flag     - unsigned A<B of the last cmp
//    dbg_sel     - debug register index
//    dbg_data    - combinational read of R[dbg_sel]
module bitty_core_param #(
   parameter int unsigned        DATA_W    = 16,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [15:0]       instruction,
   output logic              done,
   output logic              busy,
   output logic              carry_flag,
   output logic              eq_flag,
   output logic              lt_flag,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int unsigned SW = $clog2(DATA_W);
   // Sequential encoding lets the middle states simply increment.
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] EXEC = 3'd2;
   localparam logic [2:0] WB   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
   logic [2:0]        state;
   logic [15:0]       ir;
   logic [DATA_W-1:0] r [8];
   logic [DATA_W-1:0] s, c, b, alu;
   logic [DATA_W:0]   sum, diff;
   logic [2:0]        rx, ry, op;
   logic              valid;
   assign rx    = ir[15:13];
   assign ry    = ir[12:10];
   assign op    = ir[4:2];
   assign valid = ~ir[1];
   assign b     = ir[0] ? DATA_W'(ir[12:5]) : r[ry];
   assign sum   = {1'b0, s} + {1'b0, b};
   assign diff  = {1'b0, s} - {1'b0, b};
   assign busy     = state != IDLE;
   assign dbg_data = r[dbg_sel];
   always_comb begin
      alu = op == 3'd0 ? sum[DATA_W-1:0] :
            op == 3'd1 ? diff[DATA_W-1:0] :
            op == 3'd2 ? s & b :
            op == 3'd3 ? s | b :
            op == 3'd4 ? s ^ b :
            op == 3'd5 ? s << b[SW-1:0] :
            op == 3'd6 ? s >> b[SW-1:0] : s;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         done       <= 1'b0;
         carry_flag <= 1'b0;
         eq_flag    <= 1'b0;
         lt_flag    <= 1'b0;
         ir         <= 16'(RESET_VAL);
         s          <= RESET_VAL;
         c          <= RESET_VAL;
         for (int i = 0; i < 8; i++) r[i] <= RESET_VAL;
      end else begin
         // done is registered off DONE, so the pulse lands on the 4th edge after accept.
         done  <= state == DONE;
         state <= state == IDLE ? (run ? LOAD : IDLE) : state == DONE ? IDLE : state + 3'd1;
         if (state == IDLE && run) ir <= instruction;
         if (state == LOAD) s <= r[rx];
         if (state == EXEC && valid) begin
            c <= alu;
            if (op == 3'd0) carry_flag <= sum[DATA_W];
            if (op == 3'd1) carry_flag <= ~diff[DATA_W];
            if (op == 3'd7) begin
               eq_flag <= s == b;
               lt_flag <= s < b;
            end
         end
         if (state == WB && valid && op != 3'd7) r[rx] <= c;
      end
   end
endmodule

// File: tb/tb_bitty_core_param.sv
// tb_bitty_core_param: checks three widths (8/16/32) in lockstep against an arithmetic model
module tb_bitty_core_param;
   logic        clk = 1'b0;
   logic        reset, run;
   logic [15:0] instruction;
   logic [2:0]  dbg_sel;
   logic        done_v [3], busy_v [3], cf_v [3], eq_v [3], lt_v [3];
   logic [63:0] dbg_v [3];
   logic [63:0] m_r [3][8];
   logic        m_c [3], m_eq [3], m_lt [3];
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : dut_g
      localparam int W = 8 << g;
      logic [W-1:0] d;
      logic dn, bs, cf, eq, lt;
      bitty_core_param #(.DATA_W(W)) u_dut (
         .clk(clk), .reset(reset), .run(run), .instruction(instruction),
         .done(dn), .busy(bs), .carry_flag(cf), .eq_flag(eq), .lt_flag(lt),
         .dbg_sel(dbg_sel), .dbg_data(d)
      );
      assign dbg_v[g]  = 64'(d);
      assign done_v[g] = dn;
      assign busy_v[g] = bs;
      assign cf_v[g]   = cf;
      assign eq_v[g]   = eq;
      assign lt_v[g]   = lt;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] ri(input logic [2:0] rx, input logic [7:0] imm, input logic [2:0] op);
      return {rx, imm, op, 2'b01};
   endfunction
   function automatic logic [15:0] rr(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] op);
      return {rx, ry, 5'd0, op, 2'b00};
   endfunction
   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) m_r[k][i] = '0;
         m_c[k] = 1'b0; m_eq[k] = 1'b0; m_lt[k] = 1'b0;
      end
   endtask
   task automatic model_exec(input logic [15:0] ins);
      logic [2:0]  rx, ry, op;
      logic [63:0] a, b, t, mask;
      int          w;
      rx = ins[15:13]; ry = ins[12:10]; op = ins[4:2];
      if (ins[1]) return;
      for (int k = 0; k < 3; k++) begin
         w    = 8 << k;
         mask = (64'd1 << w) - 64'd1;
         a    = m_r[k][rx];
         b    = ins[0] ? 64'(ins[12:5]) : m_r[k][ry];
         t    = '0;
         case (op)
            3'd0: begin t = a + b; m_c[k] = t[w]; end
            3'd1: begin t = a - b; m_c[k] = a >= b; end
            3'd2: t = a & b;
            3'd3: t = a | b;
            3'd4: t = a ^ b;
            3'd5: t = a << (b % w);
            3'd6: t = a >> (b % w);
            default: begin m_eq[k] = a == b; m_lt[k] = a < b; end
         endcase
         if (op != 3'd7) m_r[k][rx] = t & mask;
      end
   endtask
   task automatic verify(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         for (int k = 0; k < 3; k++)
            check($sformatf("%s w%0d R%0d", tag, 8 << k, i), dbg_v[k], m_r[k][i]);
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s w%0d carry", tag, 8 << k), 64'(cf_v[k]), 64'(m_c[k]));
         check($sformatf("%s w%0d eq", tag, 8 << k), 64'(eq_v[k]), 64'(m_eq[k]));
         check($sformatf("%s w%0d lt", tag, 8 << k), 64'(lt_v[k]), 64'(m_lt[k]));
      end
   endtask
   task automatic issue(input logic [15:0] ins);
      @(negedge clk);
      instruction = ins;
      run = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b0;
      instruction = 16'($urandom);
      for (int e = 0; e <= 4; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
         end
         for (int k = 0; k < 3; k++) begin
            check($sformatf("done e%0d w%0d ins %h", e, 8 << k, ins), 64'(done_v[k]), 64'(e == 4));
            check($sformatf("busy e%0d w%0d ins %h", e, 8 << k, ins), 64'(busy_v[k]), 64'(e != 4));
         end
      end
      model_exec(ins);
      verify($sformatf("ins %h", ins));
   endtask
   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      instruction = '0;
      dbg_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask
   logic [15:0] bi [3];
   int          cnt [3];
   int          pos [3][3];
   initial begin
      do_reset();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset busy w%0d", 8 << k), 64'(busy_v[k]), 64'd0);
         check($sformatf("reset done w%0d", 8 << k), 64'(done_v[k]), 64'd0);
      end
      verify("reset");
      issue(ri(3'd1, 8'h05, 3'd0));
      dbg_sel = 3'd1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("add imm R1 w%0d", 8 << k), dbg_v[k], 64'h5);
         check($sformatf("add imm carry w%0d", 8 << k), 64'(cf_v[k]), 64'd0);
      end
      issue(ri(3'd1, 8'h05, 3'd1));
      issue(ri(3'd1, 8'h01, 3'd1));
      issue(ri(3'd1, 8'h01, 3'd0));
      dbg_sel = 3'd1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("wrap R1 w%0d", 8 << k), dbg_v[k], 64'h0);
         check($sformatf("wrap carry w%0d", 8 << k), 64'(cf_v[k]), 64'd1);
      end
      issue(ri(3'd2, 8'h03, 3'd0));
      issue(ri(3'd3, 8'h07, 3'd0));
      issue(rr(3'd2, 3'd3, 3'd1));
      issue(rr(3'd3, 3'd2, 3'd7));
      for (int k = 0; k < 3; k++) begin
         check($sformatf("cmp eq w%0d", 8 << k), 64'(eq_v[k]), 64'd0);
         check($sformatf("cmp lt w%0d", 8 << k), 64'(lt_v[k]), 64'd1);
      end
      issue(ri(3'd4, 8'h01, 3'd0));
      issue(ri(3'd4, 8'h13, 3'd5));
      issue(ri(3'd4, 8'h04, 3'd6));
      issue(ri(3'd4, 8'h09, 3'd0));
      issue(rr(3'd4, 3'd4, 3'd0));
      issue(rr(3'd4, 3'd4, 3'd1));
      issue({3'd1, 8'h55, 3'd0, 2'b10});
      issue({3'd2, 8'hAA, 3'd7, 2'b11});
      bi[0] = ri(3'd6, 8'h21, 3'd0);
      bi[1] = ri(3'd6, 8'h03, 3'd4);
      bi[2] = rr(3'd7, 3'd6, 3'd0);
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      @(negedge clk);
      instruction = bi[0];
      run = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++)
            if (done_v[k]) begin
               if (cnt[k] < 3) pos[k][cnt[k]] = c;
               cnt[k]++;
            end
         if (c == 10) run = 1'b0;
         instruction = (c < 10 && (c % 5 == 3 || c % 5 == 4)) ? bi[c / 5 + 1] : 16'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("b2b pulses w%0d", 8 << k), 64'(cnt[k]), 64'd3);
         for (int p = 0; p < 3; p++)
            if (p < cnt[k]) check($sformatf("b2b pos%0d w%0d", p, 8 << k), 64'(pos[k][p]), 64'(4 + 5 * p));
      end
      for (int i = 0; i < 3; i++) model_exec(bi[i]);
      verify("b2b");
      @(negedge clk);
      instruction = ri(3'd5, 8'h09, 3'd0);
      run = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("abort busy w%0d", 8 << k), 64'(busy_v[k]), 64'd0);
         check($sformatf("abort done w%0d", 8 << k), 64'(done_v[k]), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) cnt[k] = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) if (done_v[k]) cnt[k]++;
      end
      for (int k = 0; k < 3; k++) check($sformatf("abort no done w%0d", 8 << k), 64'(cnt[k]), 64'd0);
      dbg_sel = 3'd5;
      #1;
      for (int k = 0; k < 3; k++) check($sformatf("abort R5 w%0d", 8 << k), dbg_v[k], 64'd0);
      verify("abort");
      for (int n = 0; n < 40; n++) issue(16'($urandom));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
